sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter FIFO_AW, default 3, write FIFO depth 2**FIFO_AW entries.
REQ-002 Parameter STARVE_LIMIT, default 4, maximum consecutive read grants while the write FIFO is non-empty.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  system clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 wr_valid  in  1  write request; accepted on a clk edge when wr_valid and wr_ready are both high.
REQ-007 wr_address  in  18  write word address.
REQ-008 wr_data  in  16  write word.
REQ-009 wr_ready  out  1  high when the FIFO is not full and reset is low.
REQ-010 rd_req  in  1  read request; accepted on a clk edge when rd_req is high and rd_busy is low.
REQ-011 rd_address  in  18  read word address, sampled on acceptance.
REQ-012 rd_data  out  16  read word, valid while rd_valid is high.
REQ-013 rd_valid  out  1  one-cycle pulse per completed read.
REQ-014 rd_busy  out  1  high from read acceptance through the rd_valid cycle.
REQ-015 fifo_level  out  FIFO_AW+1  number of FIFO entries.
REQ-016 overflow  out  1  sticky; set when wr_valid is high while wr_ready is low.
REQ-017 sram_write, sram_read  out  1 each  command strobes to the SRAM controller.
REQ-018 sram_address  out  18; sram_data_write  out  16; sram_data_read  in  16; sram_ready  in  1.

Function
REQ-019 Write requests SHALL enter a first-word-fall-through FIFO; order is preserved.
REQ-020 Accepted reads SHALL set a single pending-read register; only one read is outstanding at a time.
REQ-021 FSM states SHALL be IDLE, CMD and WAIT.
REQ-022 IDLE: when sram_ready is high and work is pending, latch the granted address/data into sram_address/sram_data_write, pop the FIFO if a write is granted, then go to CMD.
REQ-023 Grant rule SHALL be read over write, except that once the starve counter reaches STARVE_LIMIT with the FIFO non-empty, the write SHALL be granted.
REQ-024 Starve counter SHALL increment on each read grant made with the FIFO non-empty, clear on any write grant, and clear on any read grant made with the FIFO empty.
REQ-025 CMD: assert exactly one of sram_read or sram_write for this single cycle, then go to WAIT.
REQ-026 WAIT: sram_address and sram_data_write SHALL be held stable; when sram_ready is high, go to IDLE.
REQ-027 On WAIT exit for a read, latch sram_data_read into rd_data, pulse rd_valid the next cycle, and drop rd_busy after that cycle.
REQ-028 sram_ready SHALL be ignored during CMD.
REQ-029 A new grant SHALL NOT occur in the same cycle as WAIT exit; minimum issue spacing is one IDLE cycle.
REQ-030 A push and a pop in the same cycle SHALL leave fifo_level unchanged, and the data SHALL remain consistent.
REQ-031 A push when full SHALL be dropped, leaving FIFO contents unchanged and setting overflow.
REQ-032 Pointers SHALL wrap modulo depth; the full/empty distinction SHALL use the extra pointer bit.
REQ-033 rd_req while rd_busy is high SHALL be ignored and SHALL NOT set any flag.
REQ-034 Nominal read latency with an idle FIFO and controller is 6 cycles: rd_req high in cycle 0, rd_valid high in cycle 6.
REQ-035 Nominal write occupancy is 5 cycles per FIFO entry, from IDLE grant to the next IDLE.

Reset
REQ-036 Reset SHALL force the FSM to IDLE, empty the FIFO, and clear pending-read, the starve counter and overflow.
REQ-037 While reset is high, wr_ready, rd_valid, rd_busy, sram_read and sram_write SHALL be 0.
REQ-038 While reset is high, rd_data, sram_address and sram_data_write SHALL be 0.
REQ-039 While reset is high, fifo_level SHALL be 0.
REQ-040 Reset mid-operation SHALL abandon the in-flight access: no rd_valid and no retry; FIFO contents are lost.
REQ-041 wr_ready SHALL rise in the first cycle after reset deasserts.

Verification
REQ-042 Single read: rd_req, rd_address=18'h00010, controller model returning 16'hA5A5 -> rd_valid in cycle 6, rd_data=16'hA5A5, rd_busy high cycles 1-6.
REQ-043 Fill FIFO: 9 back-to-back writes -> wr_ready low after the 8th, 9th dropped, overflow=1, then 8 SRAM writes in order with fifo_level reaching 0.
REQ-044 Starvation: FIFO holds 1 write, rd_req re-issued after every rd_valid -> exactly 4 reads, then 1 write, then reads resume.
REQ-045 Simultaneous: wr_valid and rd_req in the same cycle on an idle block -> read issued first, write second.
REQ-046 Reset during WAIT of a read -> no rd_valid; all outputs at reset values; fifo_level=0; next read completes normally.
REQ-047 Wrap: 20 writes at a rate of 1 per 6 cycles -> fifo_level never exceeds 2, and addresses and data reach the SRAM in order.

Source files
------------

// File: rtl/sram_arbiter.sv
// Arbitrates a FIFO of buffered writes and a single pending read onto one SRAM
// controller port; reads win unless queued writes have been passed over too often.
module sram_arbiter #(
  parameter int FIFO_AW      = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  input  logic [17:0]      wr_address,
  input  logic [15:0]      wr_data,
  output logic             wr_ready,
  input  logic             rd_req,
  input  logic [17:0]      rd_address,
  output logic [15:0]      rd_data,
  output logic             rd_valid,
  output logic             rd_busy,
  output logic [FIFO_AW:0] fifo_level,
  output logic             overflow,
  output logic             sram_write,
  output logic             sram_read,
  output logic [17:0]      sram_address,
  output logic [15:0]      sram_data_write,
  input  logic [15:0]      sram_data_read,
  input  logic             sram_ready
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int PW    = FIFO_AW + 1;
  localparam int SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic            rd_want_q, rd_want_d;
  logic            rd_busy_q, rd_busy_d;
  logic [17:0]     rd_addr_q, rd_addr_d;
  logic            op_rd_q, op_rd_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [17:0]     addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [15:0]     rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic            ovf_q, ovf_d;
  logic [33:0]     mem_q [DEPTH];

  logic            full_s, empty_s, push_s, grant_rd_s, grant_wr_s;
  logic [33:0]     head_s;

  // The extra pointer bit separates a full FIFO from an empty one.
  assign full_s  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                   (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign empty_s = (wptr_q == rptr_q);
  assign head_s  = mem_q[rptr_q[FIFO_AW-1:0]];
  assign push_s  = wr_valid && wr_ready;

  assign wr_ready        = !reset && !full_s;
  assign fifo_level      = wptr_q - rptr_q;
  assign rd_data         = rd_data_q;
  assign rd_valid        = rd_valid_q;
  assign rd_busy         = rd_busy_q;
  assign overflow        = ovf_q;
  assign sram_address    = addr_q;
  assign sram_data_write = wdata_q;
  assign sram_read       = (state_q == ST_CMD) && op_rd_q;
  assign sram_write      = (state_q == ST_CMD) && !op_rd_q;

  // Next-state logic for the FSM, FIFO pointers, read tracking and starve counter.
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    rd_want_d  = rd_want_q;
    rd_busy_d  = rd_busy_q;
    rd_addr_d  = rd_addr_q;
    op_rd_d    = op_rd_q;
    starve_d   = starve_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ovf_d      = ovf_q;
    grant_rd_s = 1'b0;
    grant_wr_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sram_ready && (rd_want_q || !empty_s)) begin
          state_d = ST_CMD;
          if (rd_want_q && (empty_s || (starve_q < STARVE_MAX))) begin
            grant_rd_s = 1'b1;
          end else begin
            grant_wr_s = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMD: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (sram_ready) begin
          state_d = ST_IDLE;
          if (op_rd_q) begin
            rd_data_d  = sram_data_read;
            rd_valid_d = 1'b1;
          end else begin
            rd_valid_d = 1'b0;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (grant_rd_s) begin
      addr_d    = rd_addr_q;
      op_rd_d   = 1'b1;
      rd_want_d = 1'b0;
      starve_d  = empty_s ? {SW{1'b0}} : starve_q + SW'(1'b1);
    end else if (grant_wr_s) begin
      addr_d   = head_s[33:16];
      wdata_d  = head_s[15:0];
      op_rd_d  = 1'b0;
      starve_d = {SW{1'b0}};
      rptr_d   = rptr_q + PW'(1'b1);
    end else begin
      addr_d = addr_q;
    end

    // Busy covers acceptance through the rd_valid cycle, so these never collide.
    if (rd_req && !rd_busy_q) begin
      rd_want_d = 1'b1;
      rd_busy_d = 1'b1;
      rd_addr_d = rd_address;
    end else if (rd_valid_q) begin
      rd_busy_d = 1'b0;
    end else begin
      rd_busy_d = rd_busy_q;
    end

    if (push_s) begin
      wptr_d = wptr_q + PW'(1'b1);
    end else begin
      wptr_d = wptr_q;
    end

    if (wr_valid && !wr_ready) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Control and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wptr_q     <= {PW{1'b0}};
      rptr_q     <= {PW{1'b0}};
      rd_want_q  <= 1'b0;
      rd_busy_q  <= 1'b0;
      rd_addr_q  <= 18'h00000;
      op_rd_q    <= 1'b0;
      starve_q   <= {SW{1'b0}};
      addr_q     <= 18'h00000;
      wdata_q    <= 16'h0000;
      rd_data_q  <= 16'h0000;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      rd_want_q  <= rd_want_d;
      rd_busy_q  <= rd_busy_d;
      rd_addr_q  <= rd_addr_d;
      op_rd_q    <= op_rd_d;
      starve_q   <= starve_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
    end
  end

  // FIFO storage; contents are meaningless once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wptr_q[FIFO_AW-1:0]] <= {wr_address, wr_data};
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a small SRAM controller model.
module tb_sram_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0;
  logic [17:0] wr_address = 18'h00000;
  logic [15:0] wr_data = 16'h0000;
  logic        wr_ready;
  logic        rd_req = 1'b0;
  logic [17:0] rd_address = 18'h00000;
  logic [15:0] rd_data;
  logic        rd_valid, rd_busy;
  logic [3:0]  fifo_level;
  logic        overflow, sram_write, sram_read;
  logic [17:0] sram_address;
  logic [15:0] sram_data_write, sram_data_read;
  logic        sram_ready;

  typedef struct {
    logic        wr;
    logic [17:0] addr;
    logic [15:0] data;
  } cmd_t;

  cmd_t        exp_q[$];
  logic [15:0] exp_rd_q[$];
  cmd_t        mon_e;
  logic [15:0] mon_d;
  int ntests = 0, nfail = 0, nvalid = 0, max_level = 0;

  // Controller model: ready drops for two cycles after each strobe, then for
  // 'recov' further cycles after the completing cycle; 'hold' forces it low.
  int   ctrl_ctr = 0;
  int   recov = 0;
  logic hold = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_read || sram_write) ctrl_ctr <= 1;
    else if (ctrl_ctr != 0) ctrl_ctr <= (ctrl_ctr >= 3 + recov) ? 0 : ctrl_ctr + 1;
  end
  assign sram_ready     = !hold && (ctrl_ctr == 0 || ctrl_ctr == 3);
  assign sram_data_read = sram_address[15:0] ^ 16'hA5B5;

  sram_arbiter #(.FIFO_AW(3), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_address(wr_address),
    .wr_data(wr_data), .wr_ready(wr_ready), .rd_req(rd_req), .rd_address(rd_address),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_busy(rd_busy), .fifo_level(fifo_level),
    .overflow(overflow), .sram_write(sram_write), .sram_read(sram_read),
    .sram_address(sram_address), .sram_data_write(sram_data_write),
    .sram_data_read(sram_data_read), .sram_ready(sram_ready)
  );

  // Scoreboard: pop the expected command / read word whenever the DUT produces one.
  always @(negedge clk) begin
    if (!reset) begin
      if (sram_read || sram_write) begin
        ntests++;
        if (exp_q.size() == 0) begin
          nfail++;
          $display("FAIL sram_cmd: got wr=%0b rd=%0b addr=%h, required no command", sram_write, sram_read, sram_address);
        end else begin
          mon_e = exp_q.pop_front();
          if ((sram_read && sram_write) || sram_write !== mon_e.wr || sram_address !== mon_e.addr ||
              (mon_e.wr && sram_data_write !== mon_e.data)) begin
            nfail++;
            $display("FAIL sram_cmd: got wr=%0b rd=%0b addr=%h data=%h, required wr=%0b addr=%h data=%h",
                     sram_write, sram_read, sram_address, sram_data_write, mon_e.wr, mon_e.addr, mon_e.data);
          end
        end
      end
      if (rd_valid) begin
        nvalid++;
        ntests++;
        if (exp_rd_q.size() == 0) begin
          nfail++;
          $display("FAIL rd_valid: got pulse data=%h, required no pulse", rd_data);
        end else begin
          mon_d = exp_rd_q.pop_front();
          if (rd_data !== mon_d) begin
            nfail++;
            $display("FAIL rd_data: got %h, required %h", rd_data, mon_d);
          end
        end
      end
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    ntests++;
    if ({wr_ready, rd_valid, rd_busy, sram_read, sram_write, overflow} !== 6'b000000) begin
      nfail++;
      $display("FAIL reset_flags: got %b, required 000000",
               {wr_ready, rd_valid, rd_busy, sram_read, sram_write, overflow});
    end
    ntests++;
    if ({rd_data, sram_address, sram_data_write} !== 50'h0) begin
      nfail++;
      $display("FAIL reset_data: got rd_data=%h addr=%h wdata=%h, required 0", rd_data, sram_address, sram_data_write);
    end
    ntests++;
    if (fifo_level !== 4'd0) begin
      nfail++;
      $display("FAIL reset_level: got %0d, required 0", fifo_level);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    ntests++;
    if (wr_ready !== 1'b1) begin
      nfail++;
      $display("FAIL wr_ready_after_reset: got %b, required 1", wr_ready);
    end
  endtask

  task automatic test_single_read();
    tick();
    rd_address = 18'h00010;
    rd_req = 1'b1;
    exp_q.push_back('{1'b0, 18'h00010, 16'h0000});
    exp_rd_q.push_back(16'hA5A5);
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k == 4) rd_req = 1'b0;
      ntests++;
      if (rd_busy !== (k >= 1 && k <= 6)) begin
        nfail++;
        $display("FAIL read_busy cycle %0d: got %b, required %b", k, rd_busy, (k >= 1 && k <= 6));
      end
      ntests++;
      if (rd_valid !== (k == 6)) begin
        nfail++;
        $display("FAIL read_valid cycle %0d: got %b, required %b", k, rd_valid, (k == 6));
      end
    end
    ntests++;
    if (exp_q.size() != 0 || exp_rd_q.size() != 0) begin
      nfail++;
      $display("FAIL read_drain: got %0d/%0d outstanding, required 0", exp_q.size(), exp_rd_q.size());
    end
  endtask

  task automatic test_fill_fifo();
    tick();
    hold = 1'b1;
    for (int i = 0; i < 9; i++) begin
      ntests++;
      if (wr_ready !== (i < 8)) begin
        nfail++;
        $display("FAIL fill_ready %0d: got %b, required %b", i, wr_ready, (i < 8));
      end
      wr_valid = 1'b1;
      wr_address = 18'h00100 + 18'(i);
      wr_data = 16'h1000 + 16'(i);
      if (i < 8) exp_q.push_back('{1'b1, wr_address, wr_data});
      tick();
    end
    wr_valid = 1'b0;
    ntests++;
    if (overflow !== 1'b1 || fifo_level !== 4'd8) begin
      nfail++;
      $display("FAIL fill_overflow: got ovf=%b level=%0d, required ovf=1 level=8", overflow, fifo_level);
    end
    hold = 1'b0;
    for (int t = 0; t < 300 && exp_q.size() != 0; t++) tick();
    repeat (6) tick();
    ntests++;
    if (exp_q.size() != 0 || fifo_level !== 4'd0) begin
      nfail++;
      $display("FAIL fill_drain: got %0d outstanding level=%0d, required 0", exp_q.size(), fifo_level);
    end
  endtask

  task automatic test_simultaneous();
    wr_valid = 1'b1; wr_address = 18'h00030; wr_data = 16'hBEEF;
    rd_req = 1'b1;   rd_address = 18'h00020;
    exp_q.push_back('{1'b0, 18'h00020, 16'h0000});
    exp_q.push_back('{1'b1, 18'h00030, 16'hBEEF});
    exp_rd_q.push_back(16'h0020 ^ 16'hA5B5);
    tick();
    wr_valid = 1'b0; rd_req = 1'b0;
    for (int t = 0; t < 100 && (exp_q.size() != 0 || exp_rd_q.size() != 0); t++) tick();
    repeat (6) tick();
    ntests++;
    if (exp_q.size() != 0 || exp_rd_q.size() != 0) begin
      nfail++;
      $display("FAIL simultaneous_drain: got %0d/%0d outstanding, required 0", exp_q.size(), exp_rd_q.size());
    end
  endtask

  task automatic test_starvation();
    int nv;
    recov = 4;
    hold = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back('{1'b0, 18'h02000 + 18'(k), 16'h0000});
    exp_q.push_back('{1'b1, 18'h02100, 16'h5A5A});
    for (int k = 4; k < 6; k++) exp_q.push_back('{1'b0, 18'h02000 + 18'(k), 16'h0000});
    for (int k = 0; k < 6; k++) exp_rd_q.push_back(16'h2000 + 16'(k) ^ 16'hA5B5);
    wr_valid = 1'b1; wr_address = 18'h02100; wr_data = 16'h5A5A;
    rd_req = 1'b1;   rd_address = 18'h02000;
    tick();
    wr_valid = 1'b0; rd_req = 1'b0; hold = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      nv = nvalid;
      for (int t = 0; t < 60 && nvalid == nv; t++) tick();
      ntests++;
      if (nvalid == nv) begin
        nfail++;
        $display("FAIL starve_timeout read %0d: got no rd_valid, required one", k - 1);
      end
      if (k < 6) begin
        rd_req = 1'b1;
        rd_address = 18'h02000 + 18'(k);
        tick();
        rd_req = 1'b0;
      end
    end
    repeat (10) tick();
    ntests++;
    if (exp_q.size() != 0 || exp_rd_q.size() != 0) begin
      nfail++;
      $display("FAIL starve_drain: got %0d/%0d outstanding, required 0", exp_q.size(), exp_rd_q.size());
    end
    recov = 0;
    repeat (6) tick();
  endtask

  task automatic test_reset_mid();
    int nv;
    nv = nvalid;
    rd_req = 1'b1;   rd_address = 18'h03000;
    wr_valid = 1'b1; wr_address = 18'h03100; wr_data = 16'h7777;
    exp_q.push_back('{1'b0, 18'h03000, 16'h0000});
    tick();
    rd_req = 1'b0; wr_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    ntests++;
    if ({wr_ready, rd_valid, rd_busy, sram_read, sram_write, overflow} !== 6'b000000 ||
        {rd_data, sram_address, sram_data_write} !== 50'h0 || fifo_level !== 4'd0) begin
      nfail++;
      $display("FAIL reset_mid_outputs: got flags=%b addr=%h level=%0d, required all 0",
               {wr_ready, rd_valid, rd_busy, sram_read, sram_write, overflow}, sram_address, fifo_level);
    end
    tick();
    reset = 1'b0;
    repeat (20) tick();
    ntests++;
    if (nvalid != nv || exp_q.size() != 0) begin
      nfail++;
      $display("FAIL reset_mid_abandon: got %0d valids %0d outstanding, required 0 and 0", nvalid - nv, exp_q.size());
    end
    rd_req = 1'b1; rd_address = 18'h03004;
    exp_q.push_back('{1'b0, 18'h03004, 16'h0000});
    exp_rd_q.push_back(16'h3004 ^ 16'hA5B5);
    tick();
    rd_req = 1'b0;
    for (int t = 0; t < 40 && nvalid == nv; t++) tick();
    ntests++;
    if (nvalid != nv + 1) begin
      nfail++;
      $display("FAIL reset_mid_next_read: got %0d valids, required 1", nvalid - nv);
    end
    repeat (4) tick();
  endtask

  task automatic test_wrap();
    logic [15:0] d;
    max_level = 0;
    for (int i = 0; i < 20; i++) begin
      d = 16'($urandom);
      wr_valid = 1'b1;
      wr_address = 18'h3FFF8 + 18'(i);
      wr_data = d;
      exp_q.push_back('{1'b1, wr_address, d});
      tick();
      wr_valid = 1'b0;
      repeat (5) tick();
    end
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) tick();
    repeat (6) tick();
    ntests++;
    if (max_level > 2) begin
      nfail++;
      $display("FAIL wrap_level: got max %0d, required <= 2", max_level);
    end
    ntests++;
    if (exp_q.size() != 0 || fifo_level !== 4'd0) begin
      nfail++;
      $display("FAIL wrap_drain: got %0d outstanding level=%0d, required 0", exp_q.size(), fifo_level);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_fill_fifo();
    test_simultaneous();
    test_starvation();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
